// File: rtl/tile_stats_accumulator_pkg.sv
// Shared types and constants for the tile statistics accumulator.
// Min/max fields in the result entry exist only when TILE_STATS_MINMAX_EN is defined.
package tile_stats_accumulator_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int PIX_VAL_W = 8;
    localparam int TILE_X_W  = 6;
    localparam int TILE_Y_W  = 5;

    localparam int DEF_IMAGE_WIDTH  = 640;
    localparam int DEF_IMAGE_HEIGHT = 480;
    localparam int DEF_TILE_SIZE    = 16;
    localparam int DEF_FIFO_DEPTH   = 4;

    localparam logic [PIX_VAL_W-1:0] MIN_INIT = 8'hFF;
    localparam logic [PIX_VAL_W-1:0] MAX_INIT = 8'h00;

    function automatic int tiles_of(input int dim, input int tile);
        return dim / tile;
    endfunction

    function automatic int log2_tile(input int tile);
        return $clog2(tile);
    endfunction

    // Sum never saturates: 8 bits of pixel plus one bit per doubling of the pixel count.
    function automatic int sum_width(input int tile);
        return PIX_VAL_W + 2 * $clog2(tile);
    endfunction

    localparam int TILES_X   = tiles_of(DEF_IMAGE_WIDTH, DEF_TILE_SIZE);
    localparam int TILES_Y   = tiles_of(DEF_IMAGE_HEIGHT, DEF_TILE_SIZE);
    localparam int LOG2_TILE = log2_tile(DEF_TILE_SIZE);
    localparam int SUM_W     = sum_width(DEF_TILE_SIZE);

    typedef struct packed {
        logic [TILE_X_W-1:0]  x;
        logic [TILE_Y_W-1:0]  y;
        logic [PIX_VAL_W-1:0] mean;
`ifdef TILE_STATS_MINMAX_EN
        logic [PIX_VAL_W-1:0] min;
        logic [PIX_VAL_W-1:0] max;
`endif
    } result_t;

    localparam int ENTRY_W = $bits(result_t);

endpackage

// File: rtl/tile_stats_accumulator_fifo.sv
// Synchronous result FIFO with a registered head entry and same-cycle push/pop.
module tile_result_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] count_next;
    logic             head_valid;
    logic             do_pop;
    logic             do_push;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        do_pop     = pop && head_valid;
        do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
        remain     = count - CNT_W'(do_pop);
        count_next = remain + CNT_W'(do_push);
        rd_next    = rd_ptr + PTR_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            // An empty FIFO forwards the incoming entry straight into the head register.
            if (count_next != '0) begin
                head_data <= (remain == '0) ? push_data : mem[rd_next];
            end
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = !head_valid;

endmodule

// File: rtl/tile_stats_accumulator.sv
// Per-tile mean/min/max over a tile-raster pixel stream, queued to a valid/ready consumer.
// Define TILE_STATS_MINMAX_EN to build the min/max comparators; otherwise o_min/o_max are 0.
module tile_stats_accumulator
    import tile_stats_accumulator_pkg::*;
#(
    parameter int IMAGE_WIDTH       = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT      = DEF_IMAGE_HEIGHT,
    parameter int TILE_SIZE         = DEF_TILE_SIZE,
    parameter int RESULT_FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 i_frame_start,
    input  logic [PIX_VAL_W-1:0] i_tile_data,
    input  logic                 i_tile_data_valid,
    output logic                 o_stat_valid,
    input  logic                 i_stat_ready,
    output logic [TILE_X_W-1:0]  o_tile_x,
    output logic [TILE_Y_W-1:0]  o_tile_y,
    output logic [PIX_VAL_W-1:0] o_mean,
    output logic [PIX_VAL_W-1:0] o_min,
    output logic [PIX_VAL_W-1:0] o_max,
    output logic                 o_overflow,
    output logic                 o_frame_done
);
    localparam int N_TILES_X = tiles_of(IMAGE_WIDTH, TILE_SIZE);
    localparam int N_TILES_Y = tiles_of(IMAGE_HEIGHT, TILE_SIZE);
    localparam int PIX_W     = 2 * log2_tile(TILE_SIZE);
    localparam int ACC_W     = sum_width(TILE_SIZE);

    localparam logic [TILE_X_W-1:0] LAST_X = TILE_X_W'(N_TILES_X - 1);
    localparam logic [TILE_Y_W-1:0] LAST_Y = TILE_Y_W'(N_TILES_Y - 1);

    state_t              state;
    logic [PIX_W-1:0]    pix_cnt;
    logic [ACC_W-1:0]    sum;
    logic [TILE_X_W-1:0] tile_x;
    logic [TILE_Y_W-1:0] tile_y;
    result_t             result;
    logic                push_pending;

    logic                beat;
    logic                last_pix;
    logic                last_tile;
    logic [PIX_W-1:0]    pix_base;
    logic [ACC_W-1:0]    sum_base;
    logic [ACC_W-1:0]    sum_next;
    logic [TILE_X_W-1:0] x_base;
    logic [TILE_Y_W-1:0] y_base;

`ifdef TILE_STATS_MINMAX_EN
    logic [PIX_VAL_W-1:0] min_acc;
    logic [PIX_VAL_W-1:0] max_acc;
    logic [PIX_VAL_W-1:0] min_base;
    logic [PIX_VAL_W-1:0] max_base;
    logic [PIX_VAL_W-1:0] min_next;
    logic [PIX_VAL_W-1:0] max_next;
`endif

    result_t head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    pop;
    logic    drop;

    // A frame start restarts accumulation in the same cycle, so a coincident beat is pixel 0 of (0,0).
    always_comb begin
        beat      = i_tile_data_valid && (i_frame_start || (state == S_ACCUM));
        pix_base  = i_frame_start ? '0 : pix_cnt;
        sum_base  = i_frame_start ? '0 : sum;
        x_base    = i_frame_start ? '0 : tile_x;
        y_base    = i_frame_start ? '0 : tile_y;
        last_pix  = (pix_base == {PIX_W{1'b1}});
        last_tile = (x_base == LAST_X) && (y_base == LAST_Y);
        sum_next  = sum_base + ACC_W'(i_tile_data);
`ifdef TILE_STATS_MINMAX_EN
        min_base  = i_frame_start ? MIN_INIT : min_acc;
        max_base  = i_frame_start ? MAX_INIT : max_acc;
        min_next  = (i_tile_data < min_base) ? i_tile_data : min_base;
        max_next  = (i_tile_data > max_base) ? i_tile_data : max_base;
`endif
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state        <= S_IDLE;
            pix_cnt      <= '0;
            sum          <= '0;
            tile_x       <= '0;
            tile_y       <= '0;
            result       <= '0;
            push_pending <= 1'b0;
            o_frame_done <= 1'b0;
`ifdef TILE_STATS_MINMAX_EN
            min_acc      <= MIN_INIT;
            max_acc      <= MAX_INIT;
`endif
        end else begin
            push_pending <= beat && last_pix;
            o_frame_done <= (state == S_DONE);

            if (i_frame_start) begin
                state   <= S_ACCUM;
                pix_cnt <= '0;
                sum     <= '0;
                tile_x  <= '0;
                tile_y  <= '0;
`ifdef TILE_STATS_MINMAX_EN
                min_acc <= MIN_INIT;
                max_acc <= MAX_INIT;
`endif
            end else if (state == S_DONE) begin
                state <= S_IDLE;
            end

            if (beat) begin
                if (last_pix) begin
                    result.x    <= x_base;
                    result.y    <= y_base;
                    result.mean <= sum_next[ACC_W-1 -: PIX_VAL_W];
`ifdef TILE_STATS_MINMAX_EN
                    result.min  <= min_next;
                    result.max  <= max_next;
                    min_acc     <= MIN_INIT;
                    max_acc     <= MAX_INIT;
`endif
                    pix_cnt <= '0;
                    sum     <= '0;
                    if (x_base == LAST_X) begin
                        tile_x <= '0;
                        tile_y <= (y_base == LAST_Y) ? '0 : y_base + TILE_Y_W'(1);
                    end else begin
                        tile_x <= x_base + TILE_X_W'(1);
                    end
                    if (last_tile) begin
                        state <= S_DONE;
                    end
                end else begin
                    pix_cnt <= pix_base + PIX_W'(1);
                    sum     <= sum_next;
`ifdef TILE_STATS_MINMAX_EN
                    min_acc <= min_next;
                    max_acc <= max_next;
`endif
                end
            end
        end
    end

    assign pop  = o_stat_valid && i_stat_ready;
    assign drop = push_pending && fifo_full && !pop;

    // A drop in the same cycle as a frame start still leaves the flag set.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_frame_start) begin
            o_overflow <= 1'b0;
        end
    end

    tile_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RESULT_FIFO_DEPTH)
    ) u_fifo (
        .clk       (iClk),
        .rst_n     (iRst),
        .push      (push_pending),
        .push_data (result),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head)
    );

    assign o_stat_valid = !fifo_empty;
    assign o_tile_x     = head.x;
    assign o_tile_y     = head.y;
    assign o_mean       = head.mean;
`ifdef TILE_STATS_MINMAX_EN
    assign o_min        = head.min;
    assign o_max        = head.max;
`else
    assign o_min        = '0;
    assign o_max        = '0;
`endif

endmodule

// File: tb/tb_tile_stats_accumulator.sv
// Scoreboard bench for tile_stats_accumulator on a 64x32 image of 16x16 tiles (4x2 tiles).
module tb_tile_stats_accumulator;

    typedef struct {
        int x;
        int y;
        int mean;
        int minV;
        int maxV;
    } expect_t;

    logic       clock;
    logic       rstN;
    logic       frameStart;
    logic [7:0] tileData;
    logic       tileValid;
    logic       statValid;
    logic       statReady;
    logic [5:0] tileX;
    logic [4:0] tileY;
    logic [7:0] meanOut;
    logic [7:0] minOut;
    logic [7:0] maxOut;
    logic       overflow;
    logic       frameDone;

    expect_t expQ[$];
    int      testCount;
    int      failCount;
    int      frameDoneCount;
    int      modelX;
    int      modelY;
    int      doneBefore;

    tile_stats_accumulator #(
        .IMAGE_WIDTH       (64),
        .IMAGE_HEIGHT      (32),
        .TILE_SIZE         (16),
        .RESULT_FIFO_DEPTH (4)
    ) dut (
        .iClk              (clock),
        .iRst              (rstN),
        .i_frame_start     (frameStart),
        .i_tile_data       (tileData),
        .i_tile_data_valid (tileValid),
        .o_stat_valid      (statValid),
        .i_stat_ready      (statReady),
        .o_tile_x          (tileX),
        .o_tile_y          (tileY),
        .o_mean            (meanOut),
        .o_min             (minOut),
        .o_max             (maxOut),
        .o_overflow        (overflow),
        .o_frame_done      (frameDone)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic startFrame();
        frameStart = 1'b1;
        nextCycle();
        frameStart = 1'b0;
        modelX = 0;
        modelY = 0;
    endtask

    // mode 0: constant value; mode 1: ramp 0..255. Results are queued only when stored=1.
    task automatic applyStimulus(input int mode, input int value, input int maxGap, input bit stored);
        expect_t e;
        int sum;
        int mn;
        int mx;
        int px;
        sum = 0;
        mn = 255;
        mx = 0;
        for (int i = 0; i < 256; i++) begin
            px = (mode == 1) ? i : value;
            sum += px;
            if (px < mn) mn = px;
            if (px > mx) mx = px;
            if (i == 255 && stored) begin
                e.x = modelX;
                e.y = modelY;
                e.mean = sum >> 8;
`ifdef TILE_STATS_MINMAX_EN
                e.minV = mn;
                e.maxV = mx;
`else
                e.minV = 0;
                e.maxV = 0;
`endif
                expQ.push_back(e);
            end
            tileData = 8'(px);
            tileValid = 1'b1;
            nextCycle();
            if (maxGap > 0) begin
                tileValid = 1'b0;
                repeat ($urandom_range(0, maxGap)) nextCycle();
            end
        end
        tileValid = 1'b0;
        if (modelX == 3) begin
            modelX = 0;
            modelY = (modelY == 1) ? 0 : modelY + 1;
        end else begin
            modelX++;
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300; i++) begin
            if (expQ.size() == 0 && !statValid) break;
            nextCycle();
        end
        checkOutput("drain_pending", expQ.size(), 0);
    endtask

    // Compare every accepted head against the oldest expected result.
    always @(negedge clock) begin
        if (rstN && statValid && statReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 1, 0);
            end else begin
                expect_t e;
                e = expQ.pop_front();
                checkOutput("res_x", tileX, e.x);
                checkOutput("res_y", tileY, e.y);
                checkOutput("res_mean", meanOut, e.mean);
                checkOutput("res_min", minOut, e.minV);
                checkOutput("res_max", maxOut, e.maxV);
            end
        end
    end

    always @(negedge clock) begin
        if (rstN && frameDone) frameDoneCount++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d results outstanding", expQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testCount = 0;
        failCount = 0;
        frameDoneCount = 0;
        modelX = 0;
        modelY = 0;
        rstN = 1'b0;
        frameStart = 1'b0;
        tileData = 8'd0;
        tileValid = 1'b0;
        statReady = 1'b0;
        repeat (3) nextCycle();
        checkOutput("reset_valid", statValid, 0);
        checkOutput("reset_x", tileX, 0);
        checkOutput("reset_y", tileY, 0);
        checkOutput("reset_mean", meanOut, 0);
        checkOutput("reset_min", minOut, 0);
        checkOutput("reset_max", maxOut, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_frame_done", frameDone, 0);
        rstN = 1'b1;
        nextCycle();

        // Constant tile and result latency
        statReady = 1'b1;
        startFrame();
        applyStimulus(0, 100, 0, 1);
        checkOutput("latency_n1_valid", statValid, 0);
        nextCycle();
        checkOutput("latency_n2_valid", statValid, 1);
        waitDrain();

        // Ramp tile with random gaps
        applyStimulus(1, 0, 3, 1);
        waitDrain();

        // Overflow with the consumer stalled
        statReady = 1'b0;
        startFrame();
        checkOutput("overflow_cleared", overflow, 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 20 + k, 0, 1);
        repeat (3) nextCycle();
        checkOutput("full_no_overflow", overflow, 0);
        checkOutput("stall_valid", statValid, 1);
        checkOutput("stall_head_x", tileX, expQ[0].x);
        checkOutput("stall_head_mean", meanOut, expQ[0].mean);
        applyStimulus(0, 24, 0, 0);
        repeat (3) nextCycle();
        checkOutput("overflow_set", overflow, 1);
        checkOutput("stall_head_mean_after_drop", meanOut, expQ[0].mean);
        statReady = 1'b1;
        waitDrain();
        checkOutput("overflow_sticky", overflow, 1);

        // Full frame, frame-done pulse, then beats ignored in idle
        startFrame();
        doneBefore = frameDoneCount;
        for (int k = 0; k < 8; k++) applyStimulus(0, 10 * k, 0, 1);
        checkOutput("frame_done_n1", frameDone, 0);
        nextCycle();
        checkOutput("frame_done_n2", frameDone, 1);
        waitDrain();
        checkOutput("frame_done_count", frameDoneCount - doneBefore, 1);
        applyStimulus(0, 99, 0, 0);
        repeat (10) nextCycle();
        checkOutput("idle_ignores_beats", statValid, 0);

        // Reset in the middle of a tile
        startFrame();
        for (int i = 0; i < 100; i++) begin
            tileData = 8'd50;
            tileValid = 1'b1;
            nextCycle();
        end
        rstN = 1'b0;
        #2;
        checkOutput("midreset_valid", statValid, 0);
        tileValid = 1'b0;
        repeat (2) nextCycle();
        rstN = 1'b1;
        nextCycle();
        applyStimulus(0, 33, 0, 0);
        repeat (5) nextCycle();
        checkOutput("post_reset_idle", statValid, 0);
        startFrame();
        applyStimulus(0, 7, 1, 1);
        waitDrain();
        repeat (5) nextCycle();
        checkOutput("single_result_only", statValid, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/tile_stats_accumulator.md
# tile_stats_accumulator

Downstream consumer of the tile-raster pixel stream produced by the tiling controller. Accumulates each TILE_SIZE×TILE_SIZE tile and computes per-tile mean, min and max, tagged with tile coordinates. Results are buffered in a small result FIFO and handed to the next stage, the feature/threshold logic, over a valid/ready handshake. The pixel input has no backpressure, so result-FIFO overflow is flagged rather than stalled.

## Interface
- IMAGE_WIDTH, 640, frame width in pixels; multiple of TILE_SIZE
- IMAGE_HEIGHT, 480, frame height in pixels; multiple of TILE_SIZE
- TILE_SIZE, 16, tile edge in pixels; power of 2, 2..16
- RESULT_FIFO_DEPTH, 4, result FIFO entries; power of 2, ≥2
- iClk  in  1  single clock; all logic on rising edge
- iRst  in  1  asynchronous, active-low reset
- i_frame_start  in  1  one-cycle pulse; arms a new frame
- i_tile_data  in  8  pixel value
- i_tile_data_valid  in  1  pixel beat qualifier; no backpressure
- o_stat_valid  out  1  FIFO head holds a result
- i_stat_ready  in  1  downstream accepts head when high with o_stat_valid
- o_tile_x  out  6  tile column of head result
- o_tile_y  out  5  tile row of head result
- o_mean  out  8  floor(sum / TILE_SIZE²)
- o_min  out  8  minimum pixel in tile
- o_max  out  8  maximum pixel in tile
- o_overflow  out  1  sticky: a result was dropped because the FIFO was full
- o_frame_done  out  1  one-cycle pulse after the last tile's result is pushed

## Operation
- FSM states:
  - S_IDLE: beats ignored; i_frame_start → S_ACCUM.
  - S_ACCUM: accumulate beats. After the last beat of tile (W/T−1, H/T−1) → S_DONE.
  - S_DONE: one cycle, o_frame_done=1; → S_IDLE.
- i_frame_start in any state:
  - clears the pixel counter, tile counters, sum, min (to 255), max (to 0), and o_overflow; enters S_ACCUM.
  - A valid beat in the same cycle is accepted as pixel 0 of tile (0,0).
  - The FIFO is not flushed.
- Pixels arrive TILE_SIZE² beats per tile, tile-internal raster order. Tiles arrive in tile-raster order (x fastest). Gaps between beats are allowed.
- Sum register width is 8+2·log2(TILE_SIZE), 16 bits at default; no saturation. Mean = sum >> 2·log2(TILE_SIZE).
- Final beat of a tile:
  - The final sum/min/max, including that beat, are captured into a result register with the current tile coordinates, and a push is pending.
  - Accumulators reset in the same cycle, so a beat in the next cycle starts the new tile.
- Tile counters: x wraps at IMAGE_WIDTH/TILE_SIZE−1 to 0 and increments y. y wraps to 0 after the frame.
- Push with FIFO full: the result is dropped and o_overflow is set. A pop in the same cycle as the push frees a slot, so the push succeeds.

## Timing
- Reset values: all outputs 0. FIFO empty, FSM S_IDLE, min accumulator 255.
- Latency: the result is pushed on cycle N+1 after the final beat at cycle N. o_stat_valid is high at cycle N+2 if the FIFO was empty. Outputs are registered from the FIFO head.
- Handshake:
  - Pop occurs when o_stat_valid && i_stat_ready.
  - Head fields are stable while o_stat_valid=1 and i_stat_ready=0.
  - o_stat_valid does not depend combinationally on i_stat_ready.
- o_frame_done pulses in the cycle after the last tile's push cycle.
- Reset mid-tile: partial accumulation, counters and FIFO contents are discarded immediately (asynchronous).

## Configuration
- TILE_STATS_MINMAX_EN defined:
  - min/max comparators and FIFO fields are present.
- Not defined:
  - no comparators; o_min and o_max are tied to 0; FIFO entry width shrinks by 16 bits.
  - Mean, coordinates and handshake are unchanged.

## Structure
- Shared package/header holds:
  - FSM state encodings;
  - derived constants TILES_X = IMAGE_WIDTH/TILE_SIZE, TILES_Y, LOG2_TILE, SUM_W;
  - result-entry field layout (x, y, mean, min, max).
- One sub-module: tile_result_fifo. It is a synchronous FIFO parameterised by width/depth, with registered head, full/empty, and simultaneous push/pop support.

## Test plan
Bench config: IMAGE_WIDTH=64, IMAGE_HEIGHT=32, TILE_SIZE=16 (4×2 tiles), depth 4.
- Frame start, 256 beats of value 100, ready=1 → one result (0,0): mean 100, min 100, max 100; o_stat_valid 2 cycles after the last beat.
- Beats 0..255 (ramp), with random 0–3 cycle gaps → sum 32640: mean 127, min 0, max 255.
- Ready held 0 for 5 tiles → 4 results queued, o_overflow=1, 5th dropped. Releasing ready drains tiles (0,0),(1,0),(2,0),(3,0) in order.
- Full frame of 8 tiles, each tile k filled with value 10·k, ready=1 → coordinates (0,0)..(3,0),(0,1)..(3,1) and means 0..70. o_frame_done pulses once; FSM returns to S_IDLE and later beats are ignored.
- Reset asserted after 100 beats, then frame start and a full tile of value 7 → only one result, mean 7, coordinates (0,0).
- Build without TILE_STATS_MINMAX_EN, ramp tile → mean 127, o_min=o_max=0.
